// File: rtl/shift_register_param.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_param
// Brief    : WIDTH-bit shift register with parallel load, logical/rotate/
//            arithmetic shifts and a counted autonomous burst engine.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module shift_register_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             data_in,
    input  logic             load,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] nbits,
    output logic [WIDTH-1:0] sreg,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_MODE_LOGICAL = 2'b00;
    localparam logic [1:0] c_MODE_ROTATE  = 2'b01;
    localparam logic [1:0] c_MODE_ARITH   = 2'b10;

    logic [WIDTH-1:0] r_sreg;
    logic             r_ser;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic             r_dir;

    logic [1:0]       w_mode;
    logic             w_dir;
    logic [WIDTH-1:0] w_shift;
    logic             w_ser;

    // A running burst uses its latched controls; otherwise the live inputs apply.
    always_comb begin
        w_mode  = r_busy ? r_mode : mode;
        w_dir   = r_busy ? r_dir  : dir;
        w_shift = r_sreg;
        w_ser   = r_ser;
        if (w_dir) begin
            case (w_mode)
                c_MODE_LOGICAL: begin
                    w_shift = {data_in, r_sreg[WIDTH-1:1]};
                    w_ser   = r_sreg[0];
                end
                c_MODE_ROTATE: begin
                    w_shift = {r_sreg[0], r_sreg[WIDTH-1:1]};
                    w_ser   = r_sreg[0];
                end
                c_MODE_ARITH: begin
                    w_shift = {r_sreg[WIDTH-1], r_sreg[WIDTH-1:1]};
                    w_ser   = r_sreg[0];
                end
                default: ;
            endcase
        end else begin
            case (w_mode)
                c_MODE_LOGICAL: begin
                    w_shift = {r_sreg[WIDTH-2:0], data_in};
                    w_ser   = r_sreg[WIDTH-1];
                end
                c_MODE_ROTATE: begin
                    w_shift = {r_sreg[WIDTH-2:0], r_sreg[WIDTH-1]};
                    w_ser   = r_sreg[WIDTH-1];
                end
                c_MODE_ARITH: begin
                    w_shift = {r_sreg[WIDTH-2:0], 1'b0};
                    w_ser   = r_sreg[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
            r_ser  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_mode <= 2'b00;
            r_dir  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                // Load aborts a burst silently: no done pulse.
                r_sreg <= par_in;
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (r_busy) begin
                r_sreg <= w_shift;
                r_ser  <= w_ser;
                r_cnt  <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (start) begin
                if (nbits != '0) begin
                    r_mode <= mode;
                    r_dir  <= dir;
                    r_cnt  <= nbits;
                    r_busy <= 1'b1;
                end else begin
                    r_done <= 1'b1;
                end
            end else if (en) begin
                r_sreg <= w_shift;
                r_ser  <= w_ser;
            end
        end
    end

    assign sreg    = r_sreg;
    assign ser_out = r_ser;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register_param
// Brief    : Directed scenarios plus randomized traffic against a word-level
//            arithmetic reference model of shift_register_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register_param;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             dir;
    logic [1:0]       mode;
    logic             data_in;
    logic             load;
    logic [WIDTH-1:0] par_in;
    logic             start;
    logic [CNT_W-1:0] nbits;
    logic [WIDTH-1:0] sreg;
    logic             ser_out;
    logic             busy;
    logic             done;

    shift_register_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .dir     (dir),
        .mode    (mode),
        .data_in (data_in),
        .load    (load),
        .par_in  (par_in),
        .start   (start),
        .nbits   (nbits),
        .sreg    (sreg),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [WIDTH-1:0] m_sreg;
    logic             m_ser;
    logic             m_busy;
    logic             m_done;
    int               m_left;
    logic [1:0]       m_mode;
    logic             m_dir;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sreg = '0; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_left = 0;  m_mode = 2'b00; m_dir = 1'b0;
    endtask

    // Word-level shift using plain arithmetic on the whole value.
    task automatic model_shift(input logic [1:0] md, input logic d, input logic din);
        logic [WIDTH-1:0] s;
        s = m_sreg;
        if (md == 2'b11) return;
        if (d) begin
            m_ser = s[0];
            case (md)
                2'b00:   m_sreg = (s >> 1) | (WIDTH'(din) << (WIDTH-1));
                2'b01:   m_sreg = (s >> 1) | (s << (WIDTH-1));
                default: m_sreg = WIDTH'($signed(s) >>> 1);
            endcase
        end else begin
            m_ser = s[WIDTH-1];
            case (md)
                2'b00:   m_sreg = (s << 1) | WIDTH'(din);
                2'b01:   m_sreg = (s << 1) | (s >> (WIDTH-1));
                default: m_sreg = s << 1;
            endcase
        end
    endtask

    task automatic model_edge();
        logic nd;
        nd = 1'b0;
        if (load) begin
            m_sreg = par_in;
            m_busy = 1'b0;
            m_left = 0;
        end else if (m_busy) begin
            model_shift(m_mode, m_dir, data_in);
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                nd = 1'b1;
            end
        end else if (start) begin
            if (nbits == 0) nd = 1'b1;
            else begin
                m_mode = mode; m_dir = dir; m_left = int'(nbits); m_busy = 1'b1;
            end
        end else if (en) begin
            model_shift(mode, dir, data_in);
        end
        m_done = nd;
    endtask

    // One clock: advance the model on the same inputs, then compare just after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("sreg", 32'(sreg), 32'(m_sreg));
        check("ser_out", 32'(ser_out), 32'(m_ser));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic idle_inputs();
        en = 1'b0; load = 1'b0; start = 1'b0;
    endtask

    int               cnt;
    logic [WIDTH-1:0] saved_sreg;
    logic             saved_ser;

    initial begin
        rst = 1'b1; idle_inputs();
        dir = 1'b0; mode = 2'b00; data_in = 1'b0; par_in = '0; nbits = '0;
        model_reset();
        #12;
        check("reset_sreg", 32'(sreg), 32'h0);
        check("reset_ser", 32'(ser_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        tick();

        // Logical left single step
        load = 1'b1; par_in = 8'hA5; tick(); idle_inputs();
        en = 1'b1; dir = 1'b0; mode = 2'b00; data_in = 1'b1; tick(); idle_inputs();
        check("lsl_sreg", 32'(sreg), 32'h4B);
        check("lsl_ser", 32'(ser_out), 32'h1);
        tick();
        check("lsl_hold", 32'(sreg), 32'h4B);

        // Rotate-right burst of 3
        load = 1'b1; par_in = 8'h81; tick(); idle_inputs();
        start = 1'b1; nbits = 4'd3; mode = 2'b01; dir = 1'b1; tick(); idle_inputs();
        check("ror_busy", 32'(busy), 32'h1);
        tick(); check("ror_s1", 32'(sreg), 32'hC0);
        tick(); check("ror_s2", 32'(sreg), 32'h60);
        tick(); check("ror_s3", 32'(sreg), 32'h30);
        check("ror_done", 32'(done), 32'h1);
        check("ror_ser", 32'(ser_out), 32'h0);
        tick(); check("ror_done_clr", 32'(done), 32'h0);

        // Arithmetic right burst and left step
        load = 1'b1; par_in = 8'h90; tick(); idle_inputs();
        start = 1'b1; nbits = 4'd2; mode = 2'b10; dir = 1'b1; tick(); idle_inputs();
        tick(); check("asr_s1", 32'(sreg), 32'hC8);
        tick(); check("asr_s2", 32'(sreg), 32'hE4);
        load = 1'b1; par_in = 8'h90; tick(); idle_inputs();
        en = 1'b1; dir = 1'b0; mode = 2'b10; tick(); idle_inputs();
        check("asl_sreg", 32'(sreg), 32'h20);
        check("asl_ser", 32'(ser_out), 32'h1);

        // Load aborts a logical burst on its second busy cycle
        start = 1'b1; nbits = 4'd5; mode = 2'b00; dir = 1'b1; data_in = 1'b1; tick(); idle_inputs();
        tick();
        load = 1'b1; par_in = 8'h3C; tick(); idle_inputs();
        check("abort_sreg", 32'(sreg), 32'h3C);
        check("abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'h0);
        end

        // Start while busy is ignored
        start = 1'b1; nbits = 4'd4; mode = 2'b01; dir = 1'b0; tick();
        nbits = 4'd7; mode = 2'b11;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick(); idle_inputs();
            if (busy) cnt++;
            else break;
        end
        check("restart_len", 32'(cnt), 32'd4);
        check("restart_done", 32'(done), 32'h1);

        // Zero-length burst
        saved_sreg = sreg;
        start = 1'b1; nbits = 4'd0; tick(); idle_inputs();
        check("zero_done", 32'(done), 32'h1);
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_sreg", 32'(sreg), 32'(saved_sreg));
        tick(); check("zero_done_clr", 32'(done), 32'h0);

        // Hold-mode burst still counts down
        saved_sreg = sreg; saved_ser = ser_out;
        start = 1'b1; nbits = 4'd4; mode = 2'b11; dir = 1'b1; tick(); idle_inputs();
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) cnt++;
            else break;
        end
        check("hold_len", 32'(cnt), 32'd4);
        check("hold_done", 32'(done), 32'h1);
        check("hold_sreg", 32'(sreg), 32'(saved_sreg));
        check("hold_ser", 32'(ser_out), 32'(saved_ser));

        // Asynchronous reset mid-burst
        load = 1'b1; par_in = 8'h5A; tick(); idle_inputs();
        start = 1'b1; nbits = 4'd6; mode = 2'b00; dir = 1'b0; tick(); idle_inputs();
        tick();
        check("rst_pre_busy", 32'(busy), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("arst_sreg", 32'(sreg), 32'h0);
        check("arst_ser", 32'(ser_out), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        model_reset();
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("arst_no_done", 32'(done), 32'h0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            load    = ($urandom_range(15) == 0);
            start   = ($urandom_range(7) == 0);
            en      = $urandom_range(1);
            dir     = $urandom_range(1);
            mode    = 2'($urandom_range(3));
            data_in = $urandom_range(1);
            par_in  = WIDTH'($urandom);
            nbits   = CNT_W'($urandom);
            tick();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
